// File: rtl/deconvolutor_if.sv
// Bus between the deconvolutor and its driver: packed command word in, packed status word out.
// io_in  = {unused, start, W[3:0], A[5:0]};  io_out = {busy, err, done, B[5:0]}.
interface deconvolutor_if;
    logic [11:0] io_in;
    logic [8:0]  io_out;

    modport master (output io_in, input  io_out);
    modport slave  (input  io_in, output io_out);
endinterface

// File: rtl/deconvolutor.sv
// Bit-serial deconvolutor: picks the lowest set bits of mask A so that popcount(A & B) = W.
// One operation spans accept edge + 6 SHIFT edges + 1 DONE edge.
module deconvolutor (
    input  logic          clock,
    input  logic          reset,
    deconvolutor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e      state_q, state_d;
    logic [5:0]  a_q, a_d;
    logic [3:0]  r_q, r_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  b_acc_q, b_acc_d;
    logic [5:0]  b_out_q, b_out_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy;

    logic        start;
    logic [5:0]  mask_in;
    logic [3:0]  weight_in;
    logic        unused_in;

    assign mask_in   = bus.io_in[5:0];
    assign weight_in = bus.io_in[9:6];
    assign start     = bus.io_in[10];
    assign unused_in = bus.io_in[11];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            b_acc_q <= '0;
            b_out_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            b_acc_q <= b_acc_d;
            b_out_q <= b_out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its held value first,
    // which keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        r_d     = r_q;
        idx_d   = idx_q;
        b_acc_d = b_acc_q;
        b_out_d = b_out_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = mask_in;
                    r_d     = weight_in;
                    b_acc_d = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // R only decrements when nonzero, so it can never wrap.
                if (a_q[0] && (r_q != 4'd0)) begin
                    b_acc_d[idx_q] = 1'b1;
                    r_d            = r_q - 4'd1;
                end else begin
                    b_acc_d[idx_q] = 1'b0;
                end
                a_d   = {1'b0, a_q[5:1]};
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                b_out_d = b_acc_q;
                done_d  = 1'b1;
                err_d   = (r_q != 4'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        bus.io_out = {busy, err_q, done_q, b_out_q};
    end
endmodule

// File: tb/tb_deconvolutor.sv
// Directed and random checks of the deconvolutor against a scoreboard of expected {err, B}.
module tb_deconvolutor;
    logic clock = 1'b0;
    logic reset = 1'b1;

    deconvolutor_if bus ();

    deconvolutor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [6:0]  sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {err, B}: lowest set bits of A first, W of them at most.
    function automatic logic [6:0] model(input logic [5:0] a, input logic [3:0] w);
        logic [5:0] b;
        int         left;
        b    = '0;
        left = int'(w);
        for (int i = 0; i < 6; i++) begin
            if (a[i] && left > 0) begin
                b[i] = 1'b1;
                left--;
            end
        end
        return {(int'(w) > $countones(a)), b};
    endfunction

    function automatic logic [11:0] cmd(input logic start, input logic [5:0] a, input logic [3:0] w);
        return {1'b0, start, w, a};
    endfunction

    task automatic pop_compare(input string tag);
        logic [6:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_B"},   32'(bus.io_out[5:0]), 32'(exp[5:0]));
            check({tag, "_err"}, 32'(bus.io_out[7]),   32'(exp[6]));
        end
    endtask

    // One full operation; inputs are scrambled while busy when scramble=1.
    task automatic run_op(input string tag, input logic [5:0] a, input logic [3:0] w,
                          input bit scramble, input bit detail);
        logic [8:0] held;
        @(negedge clock);
        bus.io_in = cmd(1'b1, a, w);
        sb_q.push_back(model(a, w));
        @(negedge clock);
        if (detail) check({tag, "_busy_after_accept"}, 32'(bus.io_out[8]), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            bus.io_in = scramble ? 12'($urandom) : 12'h000;
            @(negedge clock);
            if (detail && k < 7) check({tag, "_no_early_done"}, 32'(bus.io_out[6]), 32'd0);
        end
        bus.io_in = 12'h000;
        check({tag, "_done"}, 32'(bus.io_out[6]), 32'd1);
        check({tag, "_busy_clear"}, 32'(bus.io_out[8]), 32'd0);
        pop_compare(tag);
        if (detail) begin
            held = bus.io_out;
            @(negedge clock);
            check({tag, "_hold"}, 32'(bus.io_out), 32'(held));
        end
    endtask

    initial begin
        logic [5:0] ra;
        logic [3:0] rw;
        int         done_seen;

        bus.io_in = 12'h000;
        repeat (2) @(negedge clock);
        check("reset_io_out", 32'(bus.io_out), 32'h000);
        reset = 1'b0;

        // Directed cases
        run_op("basic",      6'b101101, 4'd2,  1'b0, 1'b1);
        run_op("all_full",   6'b111111, 4'd6,  1'b0, 1'b1);
        run_op("all_zero_w", 6'b111111, 4'd0,  1'b0, 1'b1);
        run_op("over_w",     6'b010010, 4'd3,  1'b0, 1'b1);
        run_op("empty_mask", 6'b000000, 4'd15, 1'b0, 1'b1);
        run_op("exact_w",    6'b100110, 4'd3,  1'b1, 1'b1);

        // Reset on the 3rd SHIFT edge aborts without a done pulse
        @(negedge clock);
        bus.io_in = cmd(1'b1, 6'b101101, 4'd2);
        @(negedge clock);
        bus.io_in = 12'h000;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_io_out", 32'(bus.io_out), 32'h000);
        reset = 1'b0;
        done_seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (bus.io_out[6]) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op("after_abort", 6'b000011, 4'd1, 1'b0, 1'b1);

        // Reset wins over start on the same edge
        @(negedge clock);
        reset     = 1'b1;
        bus.io_in = cmd(1'b1, 6'b111111, 4'd3);
        @(negedge clock);
        check("reset_prio_busy", 32'(bus.io_out[8]), 32'd0);
        reset     = 1'b0;
        bus.io_in = 12'h000;

        // Start held high: one op every 8 cycles, single-cycle done, busy-time inputs ignored
        @(negedge clock);
        bus.io_in = cmd(1'b1, 6'b000011, 4'd1);
        sb_q.push_back(model(6'b000011, 4'd1));
        for (int op = 0; op < 3; op++) begin
            @(negedge clock);
            check("cont_busy", 32'(bus.io_out[8]), 32'd1);
            if (op > 0) check("cont_done_one_cycle", 32'(bus.io_out[6]), 32'd0);
            for (int k = 1; k <= 7; k++) begin
                bus.io_in = 12'($urandom) | 12'h400;
                @(negedge clock);
            end
            check("cont_done", 32'(bus.io_out[6]), 32'd1);
            pop_compare("cont");
            bus.io_in = cmd(1'b1, 6'b000011, 4'd1);
            if (op < 2) sb_q.push_back(model(6'b000011, 4'd1));
        end
        bus.io_in = 12'h000;
        @(negedge clock);
        @(negedge clock);

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            ra = 6'($urandom);
            rw = 4'($urandom);
            run_op("rand", ra, rw, n[0], 1'b0);
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
